// File: rtl/timetag_cmd_pkg.sv
// Shared constants and encodings for the time-tagger host command receiver.
// Command bytes, receiver FSM states and the command decode helper.
package timetag_cmd_pkg;

  localparam logic [7:0] CMD_BYTE_START = 8'h53;
  localparam logic [7:0] CMD_BYTE_STOP  = 8'h50;
  localparam logic [7:0] CMD_BYTE_RESET = 8'h52;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_SET,
    CMD_CLR,
    CMD_RST
  } cmd_e;

  function automatic cmd_e decode_cmd(
    input logic [7:0] b,
    input logic [7:0] s,
    input logic [7:0] p,
    input logic [7:0] r
  );
    cmd_e c;
    c = CMD_NONE;
    if (b == s) c = CMD_SET;
    else if (b == p) c = CMD_CLR;
    else if (b == r) c = CMD_RST;
    return c;
  endfunction

endpackage

// File: rtl/timetag_cmd_rx_if.sv
// Host-command link bundle: serial line in, tagger controls and strobes out.
// master = receiver side, slave = host/tagger side.
interface timetag_cmd_rx_if;

  logic       rx_in;
  logic       activate;
  logic       tagger_reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       unknown_cmd;

  modport master (
    input  rx_in,
    output activate,
    output tagger_reset,
    output rx_data,
    output rx_valid,
    output frame_err,
    output unknown_cmd
  );

  modport slave (
    output rx_in,
    input  activate,
    input  tagger_reset,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  unknown_cmd
  );

endinterface

// File: rtl/uart_rx_core.sv
// UART receiver core: 2-flop synchronizer, bit-timing FSM, LSB-first shifter.
// CMD_RX_PARITY_EN adds an even-parity bit (8E1); default is 8N1.
module uart_rx_core
  import timetag_cmd_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2604
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

`ifdef CMD_RX_PARITY_EN
  localparam rx_state_e AFTER_DATA = ST_PARITY;
`else
  localparam rx_state_e AFTER_DATA = ST_STOP;
`endif

  logic            r_s1;
  logic            r_s2;
  rx_state_e       r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            r_armed;
  logic            w_half;
  logic            w_full;
  logic            w_par_err;
  logic            w_stop_smp;
  logic            w_good;

`ifdef CMD_RX_PARITY_EN
  logic r_par_err;
  assign w_par_err = r_par_err;
`else
  assign w_par_err = 1'b0;
`endif

  assign w_half     = (r_cnt == HALF_M1);
  assign w_full     = (r_cnt == FULL_M1);
  assign w_stop_smp = (r_state == ST_STOP) && w_full;
  assign w_good     = r_s2 && !w_par_err;

  assign o_byte       = r_shift;
  assign o_byte_valid = w_stop_smp && w_good;
  assign o_frame_err  = w_stop_smp && !w_good;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_armed <= 1'b1;
`ifdef CMD_RX_PARITY_EN
      r_par_err <= 1'b0;
`endif
    end else begin
      r_s1 <= i_rx;
      r_s2 <= r_s1;
      unique case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          r_bit <= '0;
          // after a frame error the line must go idle before re-arming
          if (!r_armed) begin
            r_armed <= r_s2;
          end else if (!r_s2) begin
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_half) begin
            r_cnt   <= '0;
            r_state <= r_s2 ? ST_IDLE : ST_DATA;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_DATA: begin
          if (w_full) begin
            r_cnt   <= '0;
            r_shift <= {r_s2, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= AFTER_DATA;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
`ifdef CMD_RX_PARITY_EN
        ST_PARITY: begin
          if (w_full) begin
            r_cnt     <= '0;
            r_par_err <= r_s2 ^ (^r_shift);
            r_state   <= ST_STOP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
`endif
        ST_STOP: begin
          if (w_full) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
            if (!w_good) r_armed <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/timetag_cmd_rx.sv
// Host-command front end: UART bytes -> tagger activate level and reset pulse.
// Build option CMD_RX_PARITY_EN selects 8E1 framing in uart_rx_core.
module timetag_cmd_rx
  import timetag_cmd_pkg::*;
#(
  parameter int         CLKS_PER_BIT     = 2604,
  parameter int         RST_PULSE_CYCLES = 4,
  parameter logic [7:0] CMD_START        = CMD_BYTE_START,
  parameter logic [7:0] CMD_STOP         = CMD_BYTE_STOP,
  parameter logic [7:0] CMD_RESET        = CMD_BYTE_RESET
) (
  input logic             clk,
  input logic             reset,
  timetag_cmd_rx_if.master bus
);

  localparam int RW = $clog2(RST_PULSE_CYCLES + 1);

  logic [7:0]    w_byte;
  logic          w_valid;
  logic          w_ferr;
  cmd_e          w_cmd;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_ferr;
  logic          r_unk;
  logic          r_act;
  logic          r_trst;
  logic [RW-1:0] r_rcnt;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .clk         (clk),
    .reset       (reset),
    .i_rx        (bus.rx_in),
    .o_byte      (w_byte),
    .o_byte_valid(w_valid),
    .o_frame_err (w_ferr)
  );

  assign w_cmd = decode_cmd(w_byte, CMD_START, CMD_STOP, CMD_RESET);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_unk   <= 1'b0;
      r_act   <= 1'b0;
      r_trst  <= 1'b0;
      r_rcnt  <= '0;
    end else begin
      r_valid <= w_valid;
      r_ferr  <= w_ferr;
      r_unk   <= w_valid && (w_cmd == CMD_NONE);
      // pulse trails the count by one cycle so it starts after rx_valid
      r_trst  <= (r_rcnt != '0);
      if (w_valid) r_data <= w_byte;
      if (w_valid && (w_cmd == CMD_RST)) begin
        r_rcnt <= RW'(RST_PULSE_CYCLES);
      end else if (r_rcnt != '0) begin
        r_rcnt <= r_rcnt - RW'(1);
      end
      if (w_valid) begin
        unique case (1'b1)
          (w_cmd == CMD_SET): r_act <= 1'b1;
          (w_cmd == CMD_CLR): r_act <= 1'b0;
          (w_cmd == CMD_RST): r_act <= 1'b0;
          default:            r_act <= r_act;
        endcase
      end
    end
  end

  assign bus.activate     = r_act;
  assign bus.tagger_reset = r_trst;
  assign bus.rx_data      = r_data;
  assign bus.rx_valid     = r_valid;
  assign bus.frame_err    = r_ferr;
  assign bus.unknown_cmd  = r_unk;

endmodule

// File: tb/tb_timetag_cmd_rx.sv
// Bench for timetag_cmd_rx: frame-level event model checked every cycle.
// Honours CMD_RX_PARITY_EN when the design is built with it.
module tb_timetag_cmd_rx;

  localparam int CPB  = 16;
  localparam int RPC  = 4;
  localparam int HALF = CPB / 2;
`ifdef CMD_RX_PARITY_EN
  localparam int NBIT = 10;
  localparam int LAT_LIT = 171;
`else
  localparam int NBIT = 9;
  localparam int LAT_LIT = 155;
`endif
  // 2 sync flops + 1 cycle to see start, then half bit and the rest
  localparam int LAT = 3 + HALF + NBIT * CPB;

  logic clk = 1'b0;
  logic reset = 1'b1;

  timetag_cmd_rx_if bus ();

  timetag_cmd_rx #(
    .CLKS_PER_BIT    (CPB),
    .RST_PULSE_CYCLES(RPC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at;
    logic [7:0] b;
    bit         good;
  } ev_t;

  ev_t evq[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  logic rst_q = 1'b1;

  bit         m_act = 1'b0;
  logic [7:0] m_data = 8'h00;
  int         m_rlast = -100;
  int n_valid = 0;
  int n_unk = 0;
  int n_fe = 0;
  int n_trst = 0;
  int first_valid = -1;
  int last_valid = -1;
  int first_trst = -1;
  int last_start = 0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  initial begin
    ev_t e;
    bit  e_v;
    bit  e_f;
    bit  e_u;
    bit  e_t;
    @(posedge clk);
    forever begin
      @(negedge clk);
      e_v = 1'b0;
      e_f = 1'b0;
      e_u = 1'b0;
      if (rst_q) begin
        evq.delete();
        m_act   = 1'b0;
        m_data  = 8'h00;
        m_rlast = -100;
      end else if (evq.size() > 0 && evq[0].at == cyc) begin
        e = evq.pop_front();
        if (e.good) begin
          e_v    = 1'b1;
          m_data = e.b;
          case (e.b)
            8'h53: m_act = 1'b1;
            8'h50: m_act = 1'b0;
            8'h52: begin
              m_act   = 1'b0;
              m_rlast = cyc;
            end
            default: e_u = 1'b1;
          endcase
        end else begin
          e_f = 1'b1;
        end
      end
      e_t = (cyc > m_rlast) && (cyc <= m_rlast + RPC);
      chk("rx_valid", bus.rx_valid, e_v);
      chk("frame_err", bus.frame_err, e_f);
      chk("unknown_cmd", bus.unknown_cmd, e_u);
      chk("activate", bus.activate, m_act);
      chk("rx_data", bus.rx_data, m_data);
      chk("tagger_reset", bus.tagger_reset, e_t);
      if (bus.rx_valid === 1'b1) begin
        n_valid++;
        last_valid = cyc;
        if (first_valid < 0) first_valid = cyc;
      end
      if (bus.unknown_cmd === 1'b1) n_unk++;
      if (bus.frame_err === 1'b1) n_fe++;
      if (bus.tagger_reset === 1'b1) begin
        n_trst++;
        if (first_trst < 0) first_trst = cyc;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // cut >= 0: assert reset halfway through data bit 'cut'
  task automatic send(input logic [7:0] b, input bit stopv,
                      input int cut);
    @(negedge clk);
    last_start = cyc;
    evq.push_back('{cyc + LAT, b, stopv});
    bus.rx_in = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      bus.rx_in = b[i];
      if (cut == i) begin
        idle(HALF);
        reset     = 1'b1;
        bus.rx_in = 1'b1;
        idle(3);
        reset = 1'b0;
        return;
      end
      idle(CPB);
    end
`ifdef CMD_RX_PARITY_EN
    bus.rx_in = ^b;
    idle(CPB);
`endif
    bus.rx_in = stopv;
    idle(CPB);
    bus.rx_in = 1'b1;
  endtask

  initial begin
    int s0;
    bus.rx_in = 1'b1;
    reset     = 1'b1;
    idle(4);
    reset = 1'b0;
    idle(5);
    chk("rst_act", bus.activate, 1'b0);
    chk("rst_data", bus.rx_data, 8'h00);
    chk("rst_trst", bus.tagger_reset, 1'b0);

    send(8'h53, 1'b1, -1);
    s0 = last_start;
    idle(20);
    chk("latency", first_valid - s0, LAT_LIT);
    chk("S_act", bus.activate, 1'b1);
    chk("S_data", bus.rx_data, 8'h53);
    chk("S_nvalid", n_valid, 1);

    send(8'h52, 1'b1, -1);
    idle(20);
    chk("R_act", bus.activate, 1'b0);
    chk("R_ntrst", n_trst, 4);
    chk("R_trst_start", first_trst - last_valid, 1);

    send(8'h53, 1'b1, -1);
    send(8'h41, 1'b1, -1);
    idle(20);
    chk("U_act", bus.activate, 1'b1);
    chk("U_nunk", n_unk, 1);
    chk("U_data", bus.rx_data, 8'h41);
    chk("U_ntrst", n_trst, 4);

    send(8'h53, 1'b1, -1);
    idle(20);
    chk("S2_act", bus.activate, 1'b1);
    chk("S2_nvalid", n_valid, 5);

    @(negedge clk);
    bus.rx_in = 1'b0;
    idle(5);
    bus.rx_in = 1'b1;
    idle(40);
    chk("G_nvalid", n_valid, 5);
    chk("G_nfe", n_fe, 0);

    send(8'h50, 1'b1, -1);
    idle(20);
    chk("P_act", bus.activate, 1'b0);
    chk("P_data", bus.rx_data, 8'h50);

    send(8'h53, 1'b0, -1);
    bus.rx_in = 1'b0;
    idle(200);
    bus.rx_in = 1'b1;
    idle(30);
    chk("F_nfe", n_fe, 1);
    chk("F_data", bus.rx_data, 8'h50);
    chk("F_act", bus.activate, 1'b0);
    chk("F_nvalid", n_valid, 6);

    send(8'h53, 1'b1, -1);
    idle(20);
    chk("F2_act", bus.activate, 1'b1);

    send(8'h53, 1'b1, 4);
    idle(30);
    chk("X_act", bus.activate, 1'b0);
    chk("X_data", bus.rx_data, 8'h00);
    chk("X_nvalid", n_valid, 7);

    send(8'h53, 1'b1, -1);
    idle(20);
    chk("X2_act", bus.activate, 1'b1);

    send(8'h50, 1'b1, -1);
    send(8'h53, 1'b1, -1);
    idle(20);
    chk("B_nvalid", n_valid, 10);
    chk("B_act", bus.activate, 1'b1);
    chk("B_nfe", n_fe, 1);
    chk("B_evq", evq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
